// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction-fetch stage and the IF/ID register
// consumed by decode.
package fetch_sequencer_pkg;

  localparam int PC_W   = 12;
  localparam int INST_W = 19;

  // Bubble word; deliberately non-zero because all-zero is the halt encoding.
  localparam logic [INST_W-1:0] NOP_INST = 19'h40000;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  localparam int IFID_VALID_W = 1;
  localparam int IFID_INST_W  = INST_W;
  localparam int IFID_PC_W    = PC_W;
  localparam int IFID_W       = IFID_VALID_W + IFID_INST_W + IFID_PC_W;

  typedef struct packed {
    logic                   valid;
    logic [IFID_INST_W-1:0] inst;
    logic [IFID_PC_W-1:0]   pc_plus1;
  } if_id_t;

endpackage

// File: rtl/fetch_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear, count enable and
// asynchronous active-high reset.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != {W{1'b1}})) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, fills IF/ID, applies stall and
// redirect, and drains the pipeline after fetching the all-zero halt word.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_inst,
  input  logic              imem_halt,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              if_valid,
  output logic [INST_W-1:0] if_inst,
  output logic [PC_W-1:0]   if_pc_plus1,
  output logic              halted,
  output logic [CNT_W-1:0]  fetch_count
);

  localparam int DRN_W = $clog2(DRAIN_CYCLES) + 1;

  fetch_state_e      state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              if_valid_q, if_valid_d;
  logic [INST_W-1:0] if_inst_q, if_inst_d;
  logic [PC_W-1:0]   if_pc_plus1_q, if_pc_plus1_d;
  logic              halted_q, halted_d;

  logic [PC_W-1:0]   pc_plus1;
  logic [DRN_W-1:0]  drain_cnt;
  logic              drain_last;
  logic              drain_clr;
  logic              drain_en;
  logic              fetch_en;

  assign pc_plus1   = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
  assign drain_last = (drain_cnt == DRN_W'(DRAIN_CYCLES - 1));

  sat_counter #(.W(CNT_W)) u_fetch_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .en    (fetch_en),
    .count (fetch_count)
  );

  sat_counter #(.W(DRN_W)) u_drain_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (drain_clr),
    .en    (drain_en),
    .count (drain_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_RUN;
      pc_q          <= '0;
      if_valid_q    <= 1'b0;
      if_inst_q     <= NOP_INST;
      if_pc_plus1_q <= '0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_valid_q    <= if_valid_d;
      if_inst_q     <= if_inst_d;
      if_pc_plus1_q <= if_pc_plus1_d;
      halted_q      <= halted_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (!redirect_valid && !stall && imem_halt) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (redirect_valid) begin
          state_d = ST_RUN;
        end else if (!stall && drain_last) begin
          state_d = ST_HALTED;
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  // Redirect beats stall beats halt detection beats a normal fetch.
  always_comb begin
    pc_d          = pc_q;
    if_valid_d    = if_valid_q;
    if_inst_d     = if_inst_q;
    if_pc_plus1_d = if_pc_plus1_q;
    drain_clr     = 1'b0;
    drain_en      = 1'b0;
    fetch_en      = 1'b0;
    halted_d      = (state_d == ST_HALTED);
    case (state_q)
      ST_RUN: begin
        if (redirect_valid) begin
          pc_d       = redirect_pc;
          if_valid_d = 1'b0;
          if_inst_d  = NOP_INST;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (imem_halt) begin
          if_valid_d = 1'b0;
          if_inst_d  = NOP_INST;
          drain_clr  = 1'b1;
        end else begin
          pc_d          = pc_plus1;
          if_valid_d    = 1'b1;
          if_inst_d     = imem_inst;
          if_pc_plus1_d = pc_plus1;
          fetch_en      = 1'b1;
        end
      end
      ST_DRAIN: begin
        if_valid_d = 1'b0;
        if_inst_d  = NOP_INST;
        if (redirect_valid) begin
          pc_d      = redirect_pc;
          drain_clr = 1'b1;
        end else if (!stall) begin
          drain_en = 1'b1;
        end
      end
      default: begin
        if_valid_d = 1'b0;
        if_inst_d  = NOP_INST;
      end
    endcase
  end

  assign imem_addr   = pc_q;
  assign if_valid    = if_valid_q;
  assign if_inst     = if_inst_q;
  assign if_pc_plus1 = if_pc_plus1_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: behavioural model checked every cycle plus
// directed literal expectations.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  logic              clk;
  logic              rst;
  logic [PC_W-1:0]   imem_addr;
  logic [INST_W-1:0] imem_inst;
  logic              imem_halt;
  logic              stall;
  logic              redirect_valid;
  logic [PC_W-1:0]   redirect_pc;
  logic              if_valid;
  logic [INST_W-1:0] if_inst;
  logic [PC_W-1:0]   if_pc_plus1;
  logic              halted;
  logic [15:0]       fetch_count;

  logic [INST_W-1:0] mem [0:4095];

  int n_vec = 0;
  int n_bad = 0;

  int                m_mode   = 0;
  int                m_left   = 0;
  int                m_pc     = 0;
  int                m_pcp1   = 0;
  int                m_count  = 0;
  bit                m_valid  = 1'b0;
  bit                m_halted = 1'b0;
  logic [INST_W-1:0] m_inst   = NOP_INST;

  assign imem_inst = mem[imem_addr];
  assign imem_halt = (imem_inst == '0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fetch_sequencer #(.DRAIN_CYCLES(4), .CNT_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_inst      (imem_inst),
    .imem_halt      (imem_halt),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_inst        (if_inst),
    .if_pc_plus1    (if_pc_plus1),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_left = 0; m_pc = 0; m_pcp1 = 0; m_count = 0;
    m_valid = 1'b0; m_halted = 1'b0; m_inst = NOP_INST;
  endtask

  // Modes: 0 fetching, 1 draining with m_left edges to go, 2 halted.
  task automatic model_step();
    logic [INST_W-1:0] w;
    w = mem[m_pc];
    if (m_mode == 0) begin
      if (redirect_valid) begin
        m_pc = int'(redirect_pc); m_valid = 1'b0; m_inst = NOP_INST;
      end else if (!stall) begin
        if (w == '0) begin
          m_mode = 1; m_left = 4; m_valid = 1'b0; m_inst = NOP_INST;
        end else begin
          m_inst  = w;
          m_valid = 1'b1;
          m_pc    = (m_pc + 1) % 4096;
          m_pcp1  = m_pc;
          if (m_count < 65535) m_count++;
        end
      end
    end else if (m_mode == 1) begin
      m_valid = 1'b0; m_inst = NOP_INST;
      if (redirect_valid) begin
        m_mode = 0; m_pc = int'(redirect_pc);
      end else if (!stall) begin
        m_left--;
        if (m_left == 0) begin
          m_mode = 2; m_halted = 1'b1;
        end
      end
    end else begin
      m_valid = 1'b0; m_inst = NOP_INST;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
    #1;
    chk("m_addr",  32'(imem_addr),   32'(m_pc));
    chk("m_valid", 32'(if_valid),    32'(m_valid));
    chk("m_inst",  32'(if_inst),     32'(m_inst));
    chk("m_pcp1",  32'(if_pc_plus1), 32'(m_pcp1));
    chk("m_halt",  32'(halted),      32'(m_halted));
    chk("m_count", 32'(fetch_count), 32'(m_count));
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 19'h50000 | 19'(i);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_addr",  32'(imem_addr),   32'h0);
    chk("rst_valid", 32'(if_valid),    32'h0);
    chk("rst_inst",  32'(if_inst),     32'h40000);
    chk("rst_halt",  32'(halted),      32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Free run, then a three-cycle stall at pc = 2.
    run(1);
    chk("first_inst",  32'(if_inst),     32'h50000);
    chk("first_pcp1",  32'(if_pc_plus1), 32'h1);
    chk("first_valid", 32'(if_valid),    32'h1);
    run(1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run(1);
      chk("stall_addr",  32'(imem_addr),   32'h2);
      chk("stall_cnt",   32'(fetch_count), 32'h2);
      chk("stall_inst",  32'(if_inst),     32'h50001);
    end
    stall = 1'b0;
    run(1);
    chk("resume_inst", 32'(if_inst), 32'h50002);
    run(1);
    chk("count4", 32'(fetch_count), 32'h4);
    chk("pcp1_4", 32'(if_pc_plus1), 32'h4);

    // Redirect wins over a simultaneous stall.
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 12'h0A0;
    run(1);
    stall = 1'b0; redirect_valid = 1'b0;
    chk("redir_addr",  32'(imem_addr), 32'h0A0);
    chk("redir_valid", 32'(if_valid),  32'h0);
    chk("redir_inst",  32'(if_inst),   32'h40000);
    run(1);
    chk("redir_fetch", 32'(if_inst), 32'h500A0);

    // Halt word at 8, unstalled drain.
    mem[8] = '0;
    redirect_valid = 1'b1; redirect_pc = 12'h006;
    run(1);
    redirect_valid = 1'b0;
    run(2);
    chk("pre_halt_addr", 32'(imem_addr), 32'h8);
    run(1);
    chk("drain_valid", 32'(if_valid), 32'h0);
    chk("drain_inst",  32'(if_inst),  32'h40000);
    run(3);
    chk("drain3_halt", 32'(halted), 32'h0);
    run(1);
    chk("halt4",      32'(halted),    32'h1);
    chk("halt4_addr", 32'(imem_addr), 32'h8);
    redirect_valid = 1'b1; redirect_pc = 12'h123; stall = 1'b1;
    run(2);
    redirect_valid = 1'b0; stall = 1'b0;
    chk("halted_ign_addr", 32'(imem_addr), 32'h8);
    chk("halted_sticky",   32'(halted),    32'h1);

    // Same halt, one stall cycle inside the drain.
    do_reset();
    run(8);
    chk("h8_addr", 32'(imem_addr),   32'h8);
    chk("h8_cnt",  32'(fetch_count), 32'h8);
    run(2);
    stall = 1'b1;
    run(1);
    stall = 1'b0;
    run(2);
    chk("stall_drain_halt0", 32'(halted), 32'h0);
    run(1);
    chk("stall_drain_halt1", 32'(halted), 32'h1);

    // Wrong-path halt word at 5, redirected on the second drain cycle.
    mem[8] = 19'h50008;
    mem[5] = '0;
    do_reset();
    run(6);
    run(1);
    redirect_valid = 1'b1; redirect_pc = 12'h010;
    run(1);
    redirect_valid = 1'b0;
    chk("wp_addr", 32'(imem_addr), 32'h010);
    chk("wp_halt", 32'(halted),    32'h0);
    run(1);
    chk("wp_inst",  32'(if_inst),  32'h50010);
    chk("wp_valid", 32'(if_valid), 32'h1);
    run(6);
    chk("wp_never_halt", 32'(halted), 32'h0);

    // Asynchronous reset in the middle of a drain.
    do_reset();
    run(7);
    chk("pre_rst_cnt", 32'(fetch_count), 32'h5);
    #2 rst = 1'b1;
    #1;
    chk("async_addr",  32'(imem_addr),   32'h0);
    chk("async_valid", 32'(if_valid),    32'h0);
    chk("async_inst",  32'(if_inst),     32'h40000);
    chk("async_pcp1",  32'(if_pc_plus1), 32'h0);
    chk("async_cnt",   32'(fetch_count), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run(1);
    chk("restart_inst", 32'(if_inst),   32'h50000);
    chk("restart_addr", 32'(imem_addr), 32'h1);

    // PC wrap at the top of the address space.
    redirect_valid = 1'b1; redirect_pc = 12'hFFF;
    run(1);
    redirect_valid = 1'b0;
    chk("wrap_pre", 32'(imem_addr), 32'hFFF);
    run(1);
    chk("wrap_addr", 32'(imem_addr),   32'h0);
    chk("wrap_pcp1", 32'(if_pc_plus1), 32'h0);
    chk("wrap_inst", 32'(if_inst),     32'h50FFF);
    run(2);

    // Fetch counter saturation.
    mem[5] = 19'h50005;
    do_reset();
    run(65537);
    chk("cnt_sat", 32'(fetch_count), 32'hFFFF);

    run(1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
